vproc_result_arb: RTL and testbench
===================================

VPROC_RESULT_ARB -- requirements
Module: vproc_result_arb

Interface
REQ-001 SHALL have parameter XIF_ID_W, default 3, width of XIF instruction IDs.
REQ-002 SHALL have parameter SRC_CNT, default 3, number of data-carrying result sources (1..8).
REQ-003 SHALL have parameter BUF_DEPTH, default 2, per-source result FIFO depth (power of two, >=1).
REQ-004 SHALL have parameter AGE_MAX, default 7, wait cycles after which a source is promoted (>=1).
REQ-005 SHALL have parameter DONT_CARE_ZERO, default 1'b0, drive don't-care outputs to zero instead of X.
REQ-006 clk_i  input  1  single clock; all state updates on rising edge.
REQ-007 async_rst_ni  input  1  asynchronous active-low reset.
REQ-008 result_empty_valid_i  input  1  instruction completes with no result data.
REQ-009 result_empty_id_i  input  XIF_ID_W  ID for the empty result.
REQ-010 src_valid_i  input  SRC_CNT  per-source result valid.
REQ-011 src_ready_o  output  SRC_CNT  per-source accept; equals "FIFO not full".
REQ-012 src_id_i  input  SRC_CNT*XIF_ID_W  per-source ID, packed, source 0 in LSBs.
REQ-013 src_we_i  input  SRC_CNT  per-source register write enable.
REQ-014 src_rd_i  input  SRC_CNT*5  per-source destination register.
REQ-015 src_data_i  input  SRC_CNT*32  per-source result data.
REQ-016 src_exc_i / src_exccode_i  input  SRC_CNT / SRC_CNT*6  per-source exception flag and code.
REQ-017 src_pending_o  output  SRC_CNT  per-source FIFO non-empty.
REQ-018 xif_result_if  modport vproc_xif.coproc_result  XIF result channel.

Function
REQ-019 Each source SHALL be pushed into its own FIFO when src_valid_i & src_ready_o; no combinational input-to-XIF path (minimum latency 1 cycle).
REQ-020 src_ready_o SHALL depend only on FIFO occupancy; a full FIFO stays not-ready in a cycle it is also popped.
REQ-021 An empty result SHALL set bit result_empty_id_i of an XIF_ID_CNT-bit pending bitmap; visible on XIF the next cycle.
REQ-022 Arbitration SHALL each cycle pick: lowest-index source with age==AGE_MAX and non-empty FIFO; else lowest-index non-empty FIFO; else lowest set bitmap bit; else none.
REQ-023 Per-source age counter SHALL increment (saturating at AGE_MAX) each cycle its FIFO is non-empty and it is not popped, and clear on pop or when empty.
REQ-024 result_valid SHALL be 1 iff a selection exists; pop/clear occurs only when result_valid & result_ready.
REQ-025 Source selection SHALL drive id/data/rd/we/exc/exccode from FIFO head; bitmap selection SHALL drive id=bit index, we=0, exc=0, others don't-care.
REQ-026 With no selection, we=0, exc=0, all other fields don't-care per DONT_CARE_ZERO.
REQ-027 Selection and XIF fields SHALL remain stable while result_valid & ~result_ready unless a higher-priority entry arrives or an age promotion occurs (XIF allows change).
REQ-028 Simultaneous bitmap set and clear of the same ID SHALL leave the bit set.
REQ-029 FIFO pointers SHALL wrap modulo BUF_DEPTH; simultaneous push and pop on a non-full FIFO keeps occupancy unchanged.

Reset
REQ-030 Reset SHALL clear all FIFOs, age counters and bitmap; after reset src_ready_o='1, src_pending_o='0, result_valid=0.
REQ-031 Reset mid-operation SHALL discard all buffered results without emitting them; FIFO data storage need not be reset.

Structure
REQ-032 result payload struct (we, rd[4:0], data[31:0], exc, exccode[5:0]) SHALL live in vproc_pkg; ID kept separate since width is parametric.
REQ-033 Per-source buffering SHALL be one sub-module, vproc_result_fifo, instantiated SRC_CNT times.
REQ-034 Bitmap lowest-set-bit search and selector SHALL be local to vproc_result_arb.

Verification
REQ-035 Push src1 {id=2,rd=5,data=0xDEADBEEF,we=1}, result_ready=1 -> XIF valid next cycle with those fields; pending clears after handshake.
REQ-036 src0 and src2 push same cycle, result_ready=1 -> src0 emitted first, src2 one cycle later.
REQ-037 src0 pushes continuously, src1 one entry, AGE_MAX=3 -> src1 emitted within 4 cycles after becoming head.
REQ-038 Empty results ids 5 then 1 while result_ready=0, then ready=1 -> id 1 then id 5, we=0.
REQ-039 BUF_DEPTH=2, push 2 entries to src0 with result_ready=0 -> src_ready_o[0]=0; one pop -> ready returns next cycle.
REQ-040 Assert async_rst_ni low with all FIFOs full -> result_valid=0, src_ready_o all 1 immediately; no stale result after release.

Source files
------------

// File: rtl/vproc_pkg.sv
// vproc_pkg: shared result payload type for the vector processor result path.
package vproc_pkg;
    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exc;
        logic [5:0]  exccode;
    } result_t;
endpackage

// File: rtl/vproc_xif.sv
// vproc_xif: XIF result channel between coprocessor and CPU.
interface vproc_xif #(
    parameter int XIF_ID_W = 3
);
    logic                result_valid;
    logic                result_ready;
    logic [XIF_ID_W-1:0] result_id;
    logic [31:0]         result_data;
    logic [4:0]          result_rd;
    logic                result_we;
    logic                result_exc;
    logic [5:0]          result_exccode;
    modport coproc_result (
        output result_valid, result_id, result_data, result_rd, result_we, result_exc, result_exccode,
        input  result_ready
    );
    modport cpu_result (
        input  result_valid, result_id, result_data, result_rd, result_we, result_exc, result_exccode,
        output result_ready
    );
endinterface

// File: rtl/vproc_result_fifo.sv
// vproc_result_fifo: circular buffer holding one source's results awaiting the XIF.
module vproc_result_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 48
) (
    input  logic         clk_i,
    input  logic         async_rst_ni,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    assign full  = cnt == CW'(DEPTH);
    assign empty = cnt == '0;
    assign dout  = mem[rd_ptr];
    // Power-of-two depth lets the pointers wrap naturally; depth 1 keeps them at zero.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push && DEPTH > 1);
            rd_ptr <= rd_ptr + PW'(pop && DEPTH > 1);
            cnt    <= cnt + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/vproc_result_arb.sv
// vproc_result_arb: buffers per-source results and empty-result IDs and arbitrates
// them onto the single XIF result channel with age-based starvation avoidance.
module vproc_result_arb import vproc_pkg::*; #(
    parameter int XIF_ID_W       = 3,
    parameter int SRC_CNT        = 3,
    parameter int BUF_DEPTH      = 2,
    parameter int AGE_MAX        = 7,
    parameter bit DONT_CARE_ZERO = 1'b0
) (
    input  logic                         clk_i,
    input  logic                         async_rst_ni,
    input  logic                         result_empty_valid_i,
    input  logic [XIF_ID_W-1:0]          result_empty_id_i,
    input  logic [SRC_CNT-1:0]           src_valid_i,
    output logic [SRC_CNT-1:0]           src_ready_o,
    input  logic [SRC_CNT*XIF_ID_W-1:0]  src_id_i,
    input  logic [SRC_CNT-1:0]           src_we_i,
    input  logic [SRC_CNT*5-1:0]         src_rd_i,
    input  logic [SRC_CNT*32-1:0]        src_data_i,
    input  logic [SRC_CNT-1:0]           src_exc_i,
    input  logic [SRC_CNT*6-1:0]         src_exccode_i,
    output logic [SRC_CNT-1:0]           src_pending_o,
    vproc_xif.coproc_result              xif_result_if
);
    localparam int ID_CNT = 1 << XIF_ID_W;
    localparam int PLW    = $bits(result_t);
    localparam int EW     = XIF_ID_W + PLW;
    localparam int AW     = $clog2(AGE_MAX + 1);
    localparam int SW     = SRC_CNT > 1 ? $clog2(SRC_CNT) : 1;
    logic [SRC_CNT-1:0]  full, empty, pop;
    logic [EW-1:0]       head [SRC_CNT];
    logic [AW-1:0]       age [SRC_CNT];
    logic [ID_CNT-1:0]   bitmap;
    logic [SW-1:0]       sel_src;
    logic [XIF_ID_W-1:0] sel_bit;
    logic                sel_is_src, sel_is_bit, hs;
    result_t             dc_pl, out_pl;
    assign src_ready_o   = ~full;
    assign src_pending_o = ~empty;
    assign hs            = xif_result_if.result_valid & xif_result_if.result_ready;
    for (genvar g = 0; g < SRC_CNT; g++) begin : g_src
        result_t pl;
        assign pl = '{we: src_we_i[g], rd: src_rd_i[g*5 +: 5], data: src_data_i[g*32 +: 32],
                      exc: src_exc_i[g], exccode: src_exccode_i[g*6 +: 6]};
        assign pop[g] = hs & sel_is_src & (sel_src == SW'(g));
        vproc_result_fifo #(.DEPTH(BUF_DEPTH), .W(EW)) u_fifo (
            .clk_i        (clk_i),
            .async_rst_ni (async_rst_ni),
            .push         (src_valid_i[g] & ~full[g]),
            .pop          (pop[g]),
            .din          ({src_id_i[g*XIF_ID_W +: XIF_ID_W], pl}),
            .dout         (head[g]),
            .full         (full[g]),
            .empty        (empty[g])
        );
    end
    // Age saturates so a starved source stays promoted until it is served.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            age    <= '{default: '0};
            bitmap <= '0;
        end else begin
            for (int i = 0; i < SRC_CNT; i++)
                age[i] <= (empty[i] | pop[i]) ? '0 : age[i] + AW'(age[i] != AW'(AGE_MAX));
            bitmap <= (bitmap & ~(ID_CNT'(hs & ~sel_is_src) << sel_bit))
                    | (ID_CNT'(result_empty_valid_i) << result_empty_id_i);
        end
    end
    always_comb begin
        sel_is_src = 1'b0;
        sel_src    = '0;
        sel_is_bit = 1'b0;
        sel_bit    = '0;
        for (int i = SRC_CNT - 1; i >= 0; i--)
            if (!empty[i]) begin
                sel_is_src = 1'b1;
                sel_src    = SW'(i);
            end
        for (int i = SRC_CNT - 1; i >= 0; i--)
            if (!empty[i] && age[i] == AW'(AGE_MAX)) sel_src = SW'(i);
        for (int i = ID_CNT - 1; i >= 0; i--)
            if (bitmap[i]) begin
                sel_is_bit = 1'b1;
                sel_bit    = XIF_ID_W'(i);
            end
    end
    assign dc_pl = DONT_CARE_ZERO ? '0 : 'x;
    always_comb begin
        out_pl     = dc_pl;
        out_pl.we  = 1'b0;
        out_pl.exc = 1'b0;
        if (sel_is_src) out_pl = head[sel_src][PLW-1:0];
    end
    assign xif_result_if.result_valid   = sel_is_src | sel_is_bit;
    assign xif_result_if.result_id      = sel_is_src ? head[sel_src][EW-1 -: XIF_ID_W]
                                        : sel_is_bit ? sel_bit
                                        : (DONT_CARE_ZERO ? '0 : 'x);
    assign xif_result_if.result_we      = out_pl.we;
    assign xif_result_if.result_rd      = out_pl.rd;
    assign xif_result_if.result_data    = out_pl.data;
    assign xif_result_if.result_exc     = out_pl.exc;
    assign xif_result_if.result_exccode = out_pl.exccode;
endmodule

// File: tb/tb_vproc_result_arb.sv
// tb_vproc_result_arb: directed bench with a result scoreboard checked on every XIF handshake.
module tb_vproc_result_arb;
    import vproc_pkg::*;
    typedef struct {
        logic       bm;
        logic [2:0] id;
        result_t    p;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ev;
    logic [2:0]  eid;
    logic [2:0]  valid, we, exc, src_ready, pending;
    logic [8:0]  ids;
    logic [14:0] rds;
    logic [95:0] datas;
    logic [17:0] codes;
    int          checks = 0;
    int          failures = 0;
    exp_t        q[$];
    vproc_xif #(.XIF_ID_W(3)) xif ();
    vproc_result_arb #(
        .XIF_ID_W(3), .SRC_CNT(3), .BUF_DEPTH(2), .AGE_MAX(3), .DONT_CARE_ZERO(1'b1)
    ) dut (
        .clk_i                (clk),
        .async_rst_ni         (rst_n),
        .result_empty_valid_i (ev),
        .result_empty_id_i    (eid),
        .src_valid_i          (valid),
        .src_ready_o          (src_ready),
        .src_id_i             (ids),
        .src_we_i             (we),
        .src_rd_i             (rds),
        .src_data_i           (datas),
        .src_exc_i            (exc),
        .src_exccode_i        (codes),
        .src_pending_o        (pending),
        .xif_result_if        (xif)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(string tag, logic [63:0] obs, logic [63:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask
    task automatic set_src(int s, logic [2:0] id, logic [4:0] rd, logic [31:0] d, logic w, logic e, logic [5:0] c);
        valid[s]        = 1'b1;
        ids[s*3 +: 3]   = id;
        rds[s*5 +: 5]   = rd;
        datas[s*32 +: 32] = d;
        we[s]           = w;
        exc[s]          = e;
        codes[s*6 +: 6] = c;
    endtask
    task automatic exp_src(logic [2:0] id, logic [4:0] rd, logic [31:0] d, logic w, logic e, logic [5:0] c);
        q.push_back('{bm: 1'b0, id: id, p: '{we: w, rd: rd, data: d, exc: e, exccode: c}});
    endtask
    task automatic exp_bm(logic [2:0] id);
        q.push_back('{bm: 1'b1, id: id, p: '0});
    endtask
    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) tick();
        check("drain_empty", q.size(), 0);
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && xif.result_valid && xif.result_ready) begin
            if (q.size() == 0) check("unexpected_result", xif.result_valid, 1'b0);
            else begin
                e = q.pop_front();
                if (e.bm) check("bm_result", {xif.result_id, xif.result_we, xif.result_exc}, {e.id, 2'b00});
                else check("src_result", {xif.result_id, xif.result_we, xif.result_rd, xif.result_data,
                                           xif.result_exc, xif.result_exccode}, {e.id, e.p});
            end
        end
    end
    initial begin
        rst_n = 1'b0; ev = 1'b0; eid = '0; valid = '0; we = '0; exc = '0;
        ids = '0; rds = '0; datas = '0; codes = '0; xif.result_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_ready", src_ready, 3'b111);
        check("rst_pending", pending, 3'b000);
        check("rst_valid", xif.result_valid, 1'b0);
        // single source result, one cycle latency
        xif.result_ready = 1'b1;
        exp_src(3'd2, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 6'd0);
        set_src(1, 3'd2, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 6'd0);
        tick();
        valid = '0;
        check("t1_valid", xif.result_valid, 1'b1);
        check("t1_pending", pending, 3'b010);
        tick();
        check("t1_pending_clr", pending, 3'b000);
        check("t1_idle", xif.result_valid, 1'b0);
        // simultaneous pushes resolve lowest index first
        exp_src(3'd0, 5'd1, 32'h1111_0000, 1'b1, 1'b0, 6'd0);
        exp_src(3'd4, 5'd3, 32'h2222_0000, 1'b1, 1'b1, 6'h2A);
        set_src(0, 3'd0, 5'd1, 32'h1111_0000, 1'b1, 1'b0, 6'd0);
        set_src(2, 3'd4, 5'd3, 32'h2222_0000, 1'b1, 1'b1, 6'h2A);
        tick();
        valid = '0;
        check("t2_first_id", xif.result_id, 3'd0);
        tick();
        check("t2_second_id", xif.result_id, 3'd4);
        check("t2_pending", pending, 3'b100);
        drain();
        // continuous src0 traffic must not starve src1 (AGE_MAX=3)
        for (int k = 0; k < 3; k++) exp_src(3'(k), 5'(8 + k), 32'hA000_0000 + k, 1'b1, 1'b0, 6'd0);
        exp_src(3'd7, 5'd9, 32'hB0B0_B0B0, 1'b0, 1'b1, 6'h15);
        for (int k = 3; k < 5; k++) exp_src(3'(k), 5'(8 + k), 32'hA000_0000 + k, 1'b1, 1'b0, 6'd0);
        set_src(1, 3'd7, 5'd9, 32'hB0B0_B0B0, 1'b0, 1'b1, 6'h15);
        for (int k = 0; k < 5; k++) begin
            check("t3_src0_ready", src_ready[0], 1'b1);
            set_src(0, 3'(k), 5'(8 + k), 32'hA000_0000 + k, 1'b1, 1'b0, 6'd0);
            tick();
            valid[1] = 1'b0;
            if (k == 3) check("t3_promoted_id", xif.result_id, 3'd7);
        end
        valid = '0;
        drain();
        // empty results come out lowest ID first
        xif.result_ready = 1'b0;
        ev = 1'b1; eid = 3'd5;
        tick();
        eid = 3'd1;
        tick();
        ev = 1'b0;
        check("t4_valid", xif.result_valid, 1'b1);
        check("t4_lowest_id", xif.result_id, 3'd1);
        check("t4_we", {xif.result_we, xif.result_exc}, 2'b00);
        exp_bm(3'd1);
        exp_bm(3'd5);
        xif.result_ready = 1'b1;
        tick();
        check("t4_next_id", xif.result_id, 3'd5);
        drain();
        // set and clear of the same bitmap ID in one cycle leaves it set
        xif.result_ready = 1'b0;
        ev = 1'b1; eid = 3'd3;
        tick();
        exp_bm(3'd3);
        exp_bm(3'd3);
        xif.result_ready = 1'b1;
        tick();
        ev = 1'b0;
        check("t4b_still_set", {xif.result_valid, xif.result_id}, {1'b1, 3'd3});
        drain();
        // full FIFO backpressure and recovery
        xif.result_ready = 1'b0;
        exp_src(3'd1, 5'd20, 32'hC0DE_0001, 1'b1, 1'b0, 6'd0);
        exp_src(3'd2, 5'd21, 32'hC0DE_0002, 1'b1, 1'b0, 6'd0);
        set_src(0, 3'd1, 5'd20, 32'hC0DE_0001, 1'b1, 1'b0, 6'd0);
        tick();
        set_src(0, 3'd2, 5'd21, 32'hC0DE_0002, 1'b1, 1'b0, 6'd0);
        tick();
        valid = '0;
        check("t5_full_ready", src_ready[0], 1'b0);
        check("t5_other_ready", src_ready[2:1], 2'b11);
        xif.result_ready = 1'b1;
        tick();
        xif.result_ready = 1'b0;
        check("t5_ready_back", src_ready[0], 1'b1);
        xif.result_ready = 1'b1;
        drain();
        // reset with everything full discards all buffered results
        xif.result_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 3; s++) set_src(s, 3'(s + k), 5'(s), 32'h5555_0000 + s, 1'b1, 1'b0, 6'd0);
            tick();
        end
        valid = '0;
        ev = 1'b1; eid = 3'd6;
        tick();
        ev = 1'b0;
        check("t6_all_full", src_ready, 3'b000);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", xif.result_valid, 1'b0);
        check("t6_rst_ready", src_ready, 3'b111);
        check("t6_rst_pending", pending, 3'b000);
        #2 rst_n = 1'b1;
        xif.result_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t6_no_stale", xif.result_valid, 1'b0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
